// File: rtl/video_source_mux_if.sv
// video_source_mux_if
// Bundles the selector control, timing and colour signals of video_source_mux.
//
// Handshake: sel_valid is a single-cycle strobe that qualifies sel_req in the
// same cycle. There is no ready; the mux always accepts a request, and it
// decides internally whether to keep it or drop it.
//
// Signals:
//   sel_req, sel_valid     source request from control logic
//   hs_in, vs_in, de_in    timing from the pixel timing generator
//   rgb_in                 all sources packed, source k at [k*3*CW +: 3*CW], {r,g,b}
//   hs, vs, de             timing delayed to line up with the output colour
//   r, g, b                output colour
//   sel_active             source currently on screen
//   switching              high while black frames follow a switch
//
// Modports: master drives the requests, timing and sources (for example the
// top level or a bench). slave is the mux.
interface video_source_mux_if #(
  parameter int NUM_SOURCES = 4,
  parameter int COLOR_WIDTH = 8
);
  localparam int SEL_WIDTH = $clog2(NUM_SOURCES);

  logic [SEL_WIDTH-1:0]                 sel_req;
  logic                                 sel_valid;
  logic                                 hs_in;
  logic                                 vs_in;
  logic                                 de_in;
  logic [NUM_SOURCES*3*COLOR_WIDTH-1:0] rgb_in;
  logic                                 hs;
  logic                                 vs;
  logic                                 de;
  logic [COLOR_WIDTH-1:0]               r;
  logic [COLOR_WIDTH-1:0]               g;
  logic [COLOR_WIDTH-1:0]               b;
  logic [SEL_WIDTH-1:0]                 sel_active;
  logic                                 switching;

  modport master (
    output sel_req, sel_valid, hs_in, vs_in, de_in, rgb_in,
    input  hs, vs, de, r, g, b, sel_active, switching
  );

  modport slave (
    input  sel_req, sel_valid, hs_in, vs_in, de_in, rgb_in,
    output hs, vs, de, r, g, b, sel_active, switching
  );
endinterface

// File: rtl/video_source_mux.sv
// video_source_mux
// N-source RGB selector for the HDMI path. It sits between the timing
// generator plus renderers and dvi_tx.
//   - hs/vs/de are delayed by SRC_LATENCY+1 registers. The colour is captured
//     where the timing has been delayed by SRC_LATENCY, so the colour and the
//     timing leave the block on the same cycle.
//   - A source change is held as a pending request. It takes effect only on
//     the cycle after a frame edge (vs_in going active), so a change never
//     tears a visible frame. BLANK_FRAMES black frames then follow the change.
//
// Ports:
//   clk_rgb   pixel clock
//   rst       synchronous, active-high reset
//   vif       video_source_mux_if.slave (requests, timing, sources, outputs)
module video_source_mux #(
  parameter int   NUM_SOURCES  = 4,
  parameter int   COLOR_WIDTH  = 8,
  parameter int   SRC_LATENCY  = 1,
  parameter int   BLANK_FRAMES = 1,
  parameter logic SYNC_ACTIVE  = 1'b1
) (
  input  logic              clk_rgb,
  input  logic              rst,
  video_source_mux_if.slave vif
);
  localparam int SEL_WIDTH = $clog2(NUM_SOURCES);
  localparam int L         = SRC_LATENCY + 1;
  localparam int PIX_W     = 3 * COLOR_WIDTH;
  localparam int BLANK_W   = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);

  // {hs, vs, de} value that the delay line holds after reset
  localparam logic [2:0] TM_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  // ---------------------------------------------------------------- timing
  logic [2:0] tm_pipe [L];
  logic       tap_de;

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      for (int i = 0; i < L; i++) tm_pipe[i] <= TM_IDLE;
    end else begin
      tm_pipe[0] <= {vif.hs_in, vif.vs_in, vif.de_in};
      for (int i = 1; i < L; i++) tm_pipe[i] <= tm_pipe[i-1];
    end
  end

  // de as it stands when the renderers present their colour. It is
  // SRC_LATENCY cycles behind the input, one register short of the output.
  generate
    if (SRC_LATENCY == 0) begin : g_tap_direct
      assign tap_de = vif.de_in;
    end else begin : g_tap_pipe
      assign tap_de = tm_pipe[SRC_LATENCY-1][0];
    end
  endgenerate

  // ------------------------------------------------------- source control
  logic                 vs_q;
  logic                 pending;
  logic [SEL_WIDTH-1:0] pending_sel;
  logic [SEL_WIDTH-1:0] sel_active;
  logic [BLANK_W-1:0]   blank_cnt;
  logic                 switching;
  logic                 frame_edge;
  logic                 req_in_range;
  logic                 req_take;

  assign frame_edge   = (vif.vs_in == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
  assign req_in_range = ({1'b0, vif.sel_req} < (SEL_WIDTH+1)'(NUM_SOURCES));
  // A request for the source already shown is dropped only when nothing is
  // pending. With a switch pending, it replaces that switch (last wins).
  assign req_take     = vif.sel_valid && req_in_range &&
                        !((vif.sel_req == sel_active) && !pending);

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      vs_q        <= ~SYNC_ACTIVE;
      pending     <= 1'b0;
      pending_sel <= '0;
      sel_active  <= '0;
      blank_cnt   <= '0;
      switching   <= 1'b0;
    end else begin
      vs_q <= vif.vs_in;
      if (frame_edge) begin
        if (pending) begin
          sel_active <= pending_sel;
          pending    <= 1'b0;
          blank_cnt  <= BLANK_W'(BLANK_FRAMES);
          switching  <= (BLANK_FRAMES != 0);
        end else if (blank_cnt != '0) begin
          blank_cnt <= blank_cnt - 1'b1;
          switching <= (blank_cnt != BLANK_W'(1));
        end
      end
      // This comes after the edge logic. A request on the edge cycle
      // therefore stays pending for the following edge.
      if (req_take) begin
        pending     <= 1'b1;
        pending_sel <= vif.sel_req;
      end
    end
  end

  // ---------------------------------------------------------------- colour
  logic [PIX_W-1:0] src_pix;
  logic [PIX_W-1:0] pix_q;

  always_comb begin
    src_pix = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (sel_active == SEL_WIDTH'(k)) src_pix = vif.rgb_in[k*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      pix_q <= '0;
    end else if (tap_de && !switching) begin
      pix_q <= src_pix;
    end else begin
      pix_q <= '0;
    end
  end

  // --------------------------------------------------------------- outputs
  assign vif.hs         = tm_pipe[L-1][2];
  assign vif.vs         = tm_pipe[L-1][1];
  assign vif.de         = tm_pipe[L-1][0];
  assign vif.r          = pix_q[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
  assign vif.g          = pix_q[2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign vif.b          = pix_q[COLOR_WIDTH-1:0];
  assign vif.sel_active = sel_active;
  assign vif.switching  = switching;
endmodule

// File: tb/tb_video_source_mux.sv
// tb_video_source_mux
// Two muxes run side by side from the same timing and request stimulus:
//   dut_a: 4 sources, SRC_LATENCY=1, BLANK_FRAMES=1
//   dut_b: 5 sources, SRC_LATENCY=2, BLANK_FRAMES=2 (so index 5 is out of range)
// The reference model keeps per-cycle histories of the input timing and of
// the selected colour, plus a frame-level view of the selection state.
module tb_video_source_mux;
  localparam logic SA = 1'b1;
  localparam int H_ACT = 16, H_TOT = 24, HS_B = 18, HS_E = 21;
  localparam int V_ACT = 8,  V_TOT = 12, VS_B = 9,  VS_E = 11;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int PW = 24;
  localparam logic [2:0] INACT = {~SA, ~SA, 1'b0};

  int ns  [2] = '{4, 5};
  int lat [2] = '{2, 3};
  int bf  [2] = '{1, 2};

  // ------------------------------------------------------- clock and reset
  logic clk_rgb = 1'b0;
  logic rst = 1'b1;
  always #5 clk_rgb = ~clk_rgb;

  video_source_mux_if #(.NUM_SOURCES(4), .COLOR_WIDTH(8)) if_a();
  video_source_mux_if #(.NUM_SOURCES(5), .COLOR_WIDTH(8)) if_b();

  video_source_mux #(.NUM_SOURCES(4), .COLOR_WIDTH(8), .SRC_LATENCY(1),
                     .BLANK_FRAMES(1), .SYNC_ACTIVE(1'b1))
    dut_a (.clk_rgb(clk_rgb), .rst(rst), .vif(if_a.slave));

  video_source_mux #(.NUM_SOURCES(5), .COLOR_WIDTH(8), .SRC_LATENCY(2),
                     .BLANK_FRAMES(2), .SYNC_ACTIVE(1'b1))
    dut_b (.clk_rgb(clk_rgb), .rst(rst), .vif(if_b.slave));

  // ---------------------------------------------------------- bench state
  int vectors = 0;
  int miscompares = 0;
  int cyc = 16;
  int hc = 0;
  int vc = 0;
  logic [PW-1:0] src_col [5];

  // reference model
  logic [2:0]    e_t   [2][8];   // timing as seen after reset masking, by cycle
  logic [PW-1:0] col_h [2][8];   // colour chosen for each cycle (black while blanking)
  int            m_sel [2];
  int            m_psel[2];
  int            m_blank[2];
  logic          m_pend[2];
  logic          m_vprev[2];

  // the vsync pulse must outlast the pipeline so a source change stays hidden
  int vs_run = 0;
  always @(posedge clk_rgb) begin
    if (if_a.vs_in == SA) vs_run <= vs_run + 1;
    else begin
      if (vs_run != 0) assert (vs_run > 3) else $error("vsync pulse shorter than pipeline");
      vs_run <= 0;
    end
  end

  function automatic logic [2:0] gen_tm();
    logic hs, vs, de;
    hs = (hc >= HS_B && hc < HS_E) ? SA : ~SA;
    vs = (vc >= VS_B && vc < VS_E) ? SA : ~SA;
    de = (hc < H_ACT) && (vc < V_ACT);
    return {hs, vs, de};
  endfunction

  function automatic logic [30:0] obs(input int d);
    if (d == 0)
      return {if_a.hs, if_a.vs, if_a.de, if_a.r, if_a.g, if_a.b, 1'b0, if_a.sel_active, if_a.switching};
    return {if_b.hs, if_b.vs, if_b.de, if_b.r, if_b.g, if_b.b, if_b.sel_active, if_b.switching};
  endfunction

  // output during cycle n: timing entered in cycle n-L. Colour is the choice
  // made in cycle n-1, shown only where that delayed de is high.
  function automatic logic [30:0] expv(input int d);
    logic [2:0] e;
    logic [PW-1:0] px;
    e  = e_t[d][(cyc - lat[d]) % 8];
    px = e[0] ? col_h[d][(cyc - 1) % 8] : '0;
    return {e, px, 3'(m_sel[d]), (m_blank[d] != 0)};
  endfunction

  // ----------------------------------------------------------- driver task
  task automatic cycle(input logic v, input logic [2:0] req, input logic r);
    logic [2:0] tm, rq;
    logic edge_now, old_pend;
    int old_sel;
    tm = gen_tm();
    rst = r;
    {if_a.hs_in, if_a.vs_in, if_a.de_in} = tm;
    {if_b.hs_in, if_b.vs_in, if_b.de_in} = tm;
    if_a.sel_valid = v;
    if_b.sel_valid = v;
    if_a.sel_req = req[1:0];
    if_b.sel_req = req;
    for (int k = 0; k < 5; k++) begin
      if_b.rgb_in[k*PW +: PW] = src_col[k];
      if (k < 4) if_a.rgb_in[k*PW +: PW] = src_col[k];
    end
    for (int d = 0; d < 2; d++) begin
      e_t[d][cyc % 8] = r ? INACT : tm;
      if (r) for (int k = 1; k < lat[d]; k++) e_t[d][(cyc - k) % 8] = INACT;
      col_h[d][cyc % 8] = (m_blank[d] != 0) ? '0 : src_col[m_sel[d]];
      if (r) begin
        m_sel[d] = 0; m_psel[d] = 0; m_blank[d] = 0; m_pend[d] = 1'b0; m_vprev[d] = ~SA;
      end else begin
        rq = (d == 0) ? {1'b0, req[1:0]} : req;
        old_sel = m_sel[d];
        old_pend = m_pend[d];
        edge_now = (tm[1] == SA) && (m_vprev[d] != SA);
        if (edge_now) begin
          if (m_pend[d]) begin
            m_sel[d] = m_psel[d]; m_pend[d] = 1'b0; m_blank[d] = bf[d];
          end else if (m_blank[d] > 0) begin
            m_blank[d] = m_blank[d] - 1;
          end
        end
        if (v && rq < ns[d] && !(rq == old_sel && !old_pend)) begin
          m_pend[d] = 1'b1; m_psel[d] = rq;
        end
        m_vprev[d] = tm[1];
      end
    end
    @(posedge clk_rgb);
    #1;
    cyc++;
    hc++;
    if (hc == H_TOT) begin hc = 0; vc = (vc + 1) % V_TOT; end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    int f;
    src_col[0] = 24'h112233; src_col[1] = 24'($urandom); src_col[2] = 24'hAA00FF;
    src_col[3] = 24'($urandom); src_col[4] = 24'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'd0, 1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== {INACT, 24'h0, 3'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL reset_state dut%0d got %h exp %h", d, obs(d), {INACT, 24'h0, 3'b0, 1'b0});
        end
      end
    end
    f = -1;
    for (int i = 0; i < 3*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      cycle(1'b0, 3'd0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL latency dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 1 && vc == 4 && (hc == 17 || hc == 18)) begin
        vectors++;
        if ({if_a.r, if_a.g, if_a.b} !== ((hc == 17) ? 24'h112233 : 24'h0)) begin
          miscompares++;
          $display("FAIL line_edge_colour hc%0d got %h exp %h", hc, {if_a.r, if_a.g, if_a.b},
                   (hc == 17) ? 24'h112233 : 24'h0);
        end
      end
    end
  endtask

  task automatic test_switch();
    int f;
    logic v;
    f = -1;
    for (int i = 0; i < 4*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      v = (f == 0 && vc == 3 && hc == 5);
      cycle(v, 3'd2, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL switch dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 0 && hc == 1 && (vc == 8 || vc == VS_B)) begin
        vectors++;
        if ({if_a.sel_active, if_a.switching} !== ((vc == VS_B) ? 3'b101 : 3'b000)) begin
          miscompares++;
          $display("FAIL switch_edge vc%0d got %b exp %b", vc, {if_a.sel_active, if_a.switching},
                   (vc == VS_B) ? 3'b101 : 3'b000);
        end
      end
      if (f == 1 && vc == VS_B && hc == 1) begin
        vectors++;
        if (if_a.switching !== 1'b0) begin
          miscompares++;
          $display("FAIL switch_blank_end got %b exp 0", if_a.switching);
        end
      end
      if (f == 2 && vc == 4 && hc == 5) begin
        vectors++;
        if ({if_a.r, if_a.g, if_a.b} !== 24'hAA00FF) begin
          miscompares++;
          $display("FAIL switch_new_colour got %h exp aa00ff", {if_a.r, if_a.g, if_a.b});
        end
      end
    end
  endtask

  task automatic test_last_wins();
    int f;
    logic v;
    logic [2:0] req;
    f = -1;
    for (int i = 0; i < 4*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      v = (f == 0 && hc == 2 && (vc == 1 || vc == 3 || vc == 5));
      req = (vc == 1) ? 3'd1 : (vc == 3) ? 3'd3 : 3'd5;
      cycle(v, req, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL last_wins dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 0 && vc == VS_B && hc == 1) begin
        vectors++;
        if (if_b.sel_active !== 3'd3) begin
          miscompares++;
          $display("FAIL last_wins_sel got %0d exp 3", if_b.sel_active);
        end
      end
    end
  endtask

  task automatic test_same_source();
    int f;
    logic v;
    f = -1;
    for (int i = 0; i < 5*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      v = ((f == 0 || f == 2) && vc == 3 && hc == 7);
      cycle(v, 3'd3, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL same_source dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 2 && vc == VS_B && hc == 1) begin
        vectors++;
        if ({if_a.sel_active, if_a.switching, if_b.sel_active, if_b.switching} !== 7'b11_0_011_0) begin
          miscompares++;
          $display("FAIL same_source_noblank got %b exp 1100110",
                   {if_a.sel_active, if_a.switching, if_b.sel_active, if_b.switching});
        end
      end
      if (f == 3 && vc == 4 && hc == 5) begin
        vectors++;
        if ({if_a.r, if_a.g, if_a.b} !== src_col[3]) begin
          miscompares++;
          $display("FAIL same_source_colour got %h exp %h", {if_a.r, if_a.g, if_a.b}, src_col[3]);
        end
      end
    end
  endtask

  task automatic test_collision_extend();
    int f;
    logic v;
    logic [2:0] req;
    f = -1;
    for (int i = 0; i < 6*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      v = (f == 0 && vc == VS_B && hc == 0) || (f == 2 && vc == 3 && hc == 4);
      req = (f == 0) ? 3'd2 : 3'd1;
      cycle(v, req, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL collide_extend dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 0 && vc == VS_B && hc == 1) begin
        vectors++;
        if ({if_a.sel_active, if_a.switching} !== 3'b110) begin
          miscompares++;
          $display("FAIL collide_edge got %b exp 110", {if_a.sel_active, if_a.switching});
        end
      end
      if (f == 1 && vc == VS_B && hc == 1) begin
        vectors++;
        if ({if_a.sel_active, if_a.switching} !== 3'b101) begin
          miscompares++;
          $display("FAIL collide_next got %b exp 101", {if_a.sel_active, if_a.switching});
        end
      end
      if (f >= 2 && f <= 4 && vc == VS_B && hc == 1) begin
        vectors++;
        if ({if_b.sel_active, if_b.switching} !== {3'd1, (f != 4)}) begin
          miscompares++;
          $display("FAIL extend_f%0d got %b exp %b", f, {if_b.sel_active, if_b.switching}, {3'd1, (f != 4)});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int f;
    logic v, r;
    f = -1;
    for (int i = 0; i < 5*FRAME; i++) begin
      if (hc == 0 && vc == 0) f++;
      v = (f == 0 && vc == 3 && hc == 6);
      r = (f == 1 && vc == 2 && hc < 3);
      cycle(v, 3'd2, r);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL mid_reset dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
      if (f == 1 && vc == 2 && hc == 3) begin
        vectors++;
        if ({if_a.sel_active, if_a.switching, if_b.sel_active, if_b.switching} !== 7'b0) begin
          miscompares++;
          $display("FAIL mid_reset_state got %b exp 0000000",
                   {if_a.sel_active, if_a.switching, if_b.sel_active, if_b.switching});
        end
      end
      if (f == 2 && vc == 4 && hc == 17) begin
        vectors++;
        if ({if_a.r, if_a.g, if_a.b, if_b.r, if_b.g, if_b.b} !== {24'h112233, 24'h112233}) begin
          miscompares++;
          $display("FAIL mid_reset_video got %h exp 112233112233",
                   {if_a.r, if_a.g, if_a.b, if_b.r, if_b.g, if_b.b});
        end
      end
    end
  endtask

  task automatic test_random();
    logic v, r;
    logic [2:0] req;
    for (int i = 0; i < 10*FRAME; i++) begin
      for (int k = 0; k < 5; k++) src_col[k] = 24'($urandom);
      v = ($urandom_range(0, 149) == 0);
      req = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 1999) == 0);
      cycle(v, req, r);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d got %h exp %h", d, cyc, obs(d), expv(d));
        end
      end
    end
  endtask

  // ---------------------------------------------------------- sequence/report
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 8; s++) begin e_t[d][s] = INACT; col_h[d][s] = '0; end
      m_sel[d] = 0; m_psel[d] = 0; m_blank[d] = 0; m_pend[d] = 1'b0; m_vprev[d] = ~SA;
    end
    if_a.sel_valid = 1'b0; if_b.sel_valid = 1'b0;
    if_a.sel_req = '0;     if_b.sel_req = '0;
    if_a.rgb_in = '0;      if_b.rgb_in = '0;
    {if_a.hs_in, if_a.vs_in, if_a.de_in} = INACT;
    {if_b.hs_in, if_b.vs_in, if_b.de_in} = INACT;
    @(posedge clk_rgb);
    #1;
    test_reset();
    test_switch();
    test_last_wins();
    test_same_source();
    test_collision_extend();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/video_source_mux.md
Name: video_source_mux

Overview:
- Parametrised N-source RGB selector for the HDMI video path. It sits between the pixel timing generator plus the pattern/game renderers and dvi_tx.
- It delays hs/vs/de to match renderer pixel latency, so timing and colour leave the block aligned.
- Source switches take effect only at a frame boundary, followed by a programmable number of black frames, so the screen never tears mid-frame.
- It replaces ad-hoc combinational switch decoding at top level.

Parameters:
- NUM_SOURCES, 4, number of RGB sources (>=2); SEL_WIDTH = $clog2(NUM_SOURCES), local.
- COLOR_WIDTH, 8, bits per colour channel.
- SRC_LATENCY, 1, clock cycles from x/y/timing to valid source RGB (>=0).
- BLANK_FRAMES, 1, full frames forced black after a switch (0 = none).
- SYNC_ACTIVE, 1'b1, active level of hs/vs.

Ports:
- clk_rgb  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- sel_req  in  SEL_WIDTH  requested source index.
- sel_valid  in  1  single-cycle strobe qualifying sel_req.
- hs_in, vs_in, de_in  in  1 each  timing from the pixel timing generator.
- rgb_in  in  NUM_SOURCES*3*COLOR_WIDTH  source k occupies bits [k*3*CW +: 3*CW], ordered {r,g,b}, r in MSBs.
- hs, vs, de  out  1 each  delayed timing.
- r, g, b  out  COLOR_WIDTH each  output colour.
- sel_active  out  SEL_WIDTH  source currently displayed.
- switching  out  1  high while blanking frames are in progress.

Behaviour:
- Reset, held one or more cycles: hs=vs=~SYNC_ACTIVE, de=0, r=g=b=0, sel_active=0, switching=0, pending flag cleared, blank counter=0, all delay-line stages at the inactive level.
- Timing path: hs/vs/de equal hs_in/vs_in/de_in delayed by L=SRC_LATENCY+1 cycles (all registered).
- Colour path:
  - rgb_in is sampled at stage SRC_LATENCY of the timing delay line.
  - The slice for sel_active is muxed there and registered into r/g/b.
  - Result: r/g/b are aligned with de at the output.
- Colour is forced to 0 in the output register whenever delayed de=0 or switching=1.
- Request capture, on a cycle with sel_valid=1:
  - sel_req >= NUM_SOURCES: ignored, pending state unchanged.
  - Otherwise pending_sel <= sel_req and the pending flag is set. Last request before a frame edge wins.
  - If the request equals sel_active and no switch is pending, it is ignored (no blanking).
- Frame edge: the cycle where vs_in transitions to SYNC_ACTIVE, detected against a registered copy of vs_in.
- At a frame edge with the pending flag set, on the next cycle:
  - sel_active <= pending_sel and the pending flag clears.
  - blank_cnt <= BLANK_FRAMES; switching = (blank_cnt != 0).
- At a frame edge with no pending switch: if blank_cnt != 0, it decrements. switching drops the cycle after the count reaches 0.
- BLANK_FRAMES=1 therefore blanks exactly the one frame that starts at the switching edge.
- sel_valid on the same cycle as a frame edge: the edge acts on the old pending state. The new request stays pending until the next edge.
- A request accepted while blanking: it applies at the next edge and reloads blank_cnt (blanking extends).
- Constraint: SRC_LATENCY+1 < vsync pulse width, so the mux change is never visible in active video. The bench checks this with an assertion.
- Reset asserted mid-frame or mid-blank: returns to reset state immediately. Outputs stay inactive until L cycles of valid input have propagated.

Test Plan:
- Reset/latency:
  - Stimulus: rst for 3 cycles, then NUM_SOURCES=4, SRC_LATENCY=1, 16x8 active frame; source 0 = constant 0x112233.
  - Required: hs/vs/de equal the inputs delayed by exactly 2 cycles. r,g,b = 0x11,0x22,0x33 only while de=1, 0 otherwise. All outputs 0/inactive during reset.
- Frame-synchronous switch:
  - Stimulus: sel_req=2 pulsed mid-frame; source 2 = 0xAA00FF.
  - Required: output unchanged until the next vs edge. sel_active=2 one cycle after the edge. switching=1 for exactly one frame with black pixels, then 0xAA00FF.
- Last-wins and invalid requests:
  - Stimulus: within one frame, requests 1, 3, then 5 (>=NUM_SOURCES).
  - Required: at the edge, sel_active=3. Index 5 is ignored.
- Same-source request:
  - Stimulus: sel_req=sel_active.
  - Required: switching stays 0 and no frame is blanked.
- Edge collision and blank extension:
  - Stimulus: request on the exact vs edge cycle. Separately, a request during the blank frame with BLANK_FRAMES=2.
  - Required: the first applies one frame later. The second reloads the count to 2 blank frames after its edge.
- Mid-operation reset:
  - Stimulus: rst asserted during a blank frame.
  - Required: sel_active=0, switching=0, and normal source-0 video from the first full frame after release.
